nf_ram_arb: RTL and testbench

- Two-requester arbiter that shares one single-port RAM (registered read, 1-cycle latency) between the instruction-fetch port (requester 0) and the data/AHB port (requester 1).
- Sits between the core-side request ports and the RAM macro.
- Round-robin arbitration, plus an optional locked burst mode with a bounded hold time so neither side starves.

---
 rtl/nf_ram_arb.sv | 139 +++++++++++++
 tb/tb_nf_ram_arb.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/nf_ram_arb.sv
// nf_ram_arb: shares one single-port RAM (registered read, 1-cycle latency)
// between the instruction-fetch port (requester 0) and the data/AHB port
// (requester 1). Round-robin arbitration with an optional locked burst whose
// length is capped at MAX_BURST consecutive grants so neither side starves.
//
// Ports:
//   hclk, hresetn              clock, synchronous active-low reset
//   req_i, lock_i              request valid / locked-burst request
//   addr_i, we_i, wd_i         request address, write flag, write data
//   gnt_i                      request accepted this cycle (combinational)
//   rvalid_i, rd_i             read data return, one cycle after the grant
//   ram_addr, ram_wd, ram_we   RAM command for the granted requester
//   ram_rd                     RAM read data (valid the cycle after address)
module nf_ram_arb #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              req_0,
  input  logic              req_1,
  input  logic              lock_0,
  input  logic              lock_1,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic              we_0,
  input  logic              we_1,
  input  logic [DATA_W-1:0] wd_0,
  input  logic [DATA_W-1:0] wd_1,
  output logic              gnt_0,
  output logic              gnt_1,
  output logic              rvalid_0,
  output logic              rvalid_1,
  output logic [DATA_W-1:0] rd_0,
  output logic [DATA_W-1:0] rd_1,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wd,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rd
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic {ARB, OWN} state_t;

  state_t           state, state_nxt;
  logic             rr_ptr, rr_nxt;
  logic             owner, owner_nxt;
  logic [CNT_W-1:0] burst_cnt, cnt_nxt;
  logic             rd_pend, rd_owner;

  logic pick, pick_lock, own_req, own_lock;
  logic rd_grant;

  assign own_req   = owner ? req_1  : req_0;
  assign own_lock  = owner ? lock_1 : lock_0;
  assign pick_lock = pick  ? lock_1 : lock_0;

  always_comb begin
    gnt_0     = 1'b0;
    gnt_1     = 1'b0;
    state_nxt = state;
    rr_nxt    = rr_ptr;
    owner_nxt = owner;
    cnt_nxt   = burst_cnt;

    // Round-robin choice; only meaningful when at least one request is up.
    pick = rr_ptr;
    if (req_0 && !req_1)
      pick = 1'b0;
    else if (!req_0 && req_1)
      pick = 1'b1;

    if (hresetn) begin
      if (state == OWN && own_lock) begin
        // Locked owner: the other side is blocked; an idle owner keeps the lock.
        if (own_req) begin
          gnt_0  = ~owner;
          gnt_1  = owner;
          rr_nxt = ~owner;
          if (burst_cnt == CNT_LAST) begin
            // Forced release: rr_ptr already points at the other requester.
            state_nxt = ARB;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = burst_cnt + CNT_ONE;
          end
        end
      end else begin
        // ARB, or OWN with the owner's lock dropped: plain round-robin cycle.
        state_nxt = ARB;
        cnt_nxt   = '0;
        if (req_0 || req_1) begin
          gnt_0  = ~pick;
          gnt_1  = pick;
          rr_nxt = ~pick;
          if (pick_lock && MAX_BURST > 1) begin
            state_nxt = OWN;
            owner_nxt = pick;
            cnt_nxt   = CNT_ONE;
          end
        end
      end
    end
  end

  assign ram_addr = gnt_1 ? addr_1 : addr_0;
  assign ram_wd   = gnt_1 ? wd_1   : wd_0;
  assign ram_we   = (gnt_0 & we_0) | (gnt_1 & we_1);
  assign rd_grant = (gnt_0 & ~we_0) | (gnt_1 & ~we_1);

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state     <= ARB;
      rr_ptr    <= 1'b0;
      owner     <= 1'b0;
      burst_cnt <= '0;
      rd_pend   <= 1'b0;
      rd_owner  <= 1'b0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_nxt;
      owner     <= owner_nxt;
      burst_cnt <= cnt_nxt;
      rd_pend   <= rd_grant;
      if (rd_grant)
        rd_owner <= gnt_1;
    end
  end

  assign rvalid_0 = rd_pend & ~rd_owner;
  assign rvalid_1 = rd_pend & rd_owner;
  assign rd_0     = ram_rd;
  assign rd_1     = ram_rd;

endmodule

// File: tb/tb_nf_ram_arb.sv
// tb_nf_ram_arb: directed self-checking bench for nf_ram_arb (MAX_BURST=8).
// The RAM model returns {16'hDEAD, addr[15:0]} one cycle after the address.
module tb_nf_ram_arb;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        req_0, req_1, lock_0, lock_1, we_0, we_1;
  logic [31:0] addr_0, addr_1, wd_0, wd_1;
  logic        gnt_0, gnt_1, rvalid_0, rvalid_1, ram_we;
  logic [31:0] rd_0, rd_1, ram_addr, ram_wd;
  logic [31:0] ram_rd;

  int n_cmp = 0;
  int n_err = 0;

  always #5 hclk = ~hclk;

  always @(posedge hclk) ram_rd <= {16'hDEAD, ram_addr[15:0]};

  nf_ram_arb #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(8)) dut (
    .hclk(hclk), .hresetn(hresetn),
    .req_0(req_0), .req_1(req_1), .lock_0(lock_0), .lock_1(lock_1),
    .addr_0(addr_0), .addr_1(addr_1), .we_0(we_0), .we_1(we_1),
    .wd_0(wd_0), .wd_1(wd_1), .gnt_0(gnt_0), .gnt_1(gnt_1),
    .rvalid_0(rvalid_0), .rvalid_1(rvalid_1), .rd_0(rd_0), .rd_1(rd_1),
    .ram_addr(ram_addr), .ram_wd(ram_wd), .ram_we(ram_we), .ram_rd(ram_rd)
  );

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic idle();
    req_0 = 0; req_1 = 0; lock_0 = 0; lock_1 = 0; we_0 = 0; we_1 = 0;
    addr_0 = '0; addr_1 = '0; wd_0 = '0; wd_1 = '0;
  endtask

  task automatic do_reset();
    idle();
    hresetn = 0;
    tick();
    tick();
    hresetn = 1;
  endtask

  task automatic test_reset();
    idle();
    hresetn = 0; req_0 = 1; req_1 = 1; we_0 = 1; addr_0 = 32'h100;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      n_cmp++;
      if ({gnt_0, gnt_1, ram_we, rvalid_0, rvalid_1} !== 5'b0) begin
        n_err++;
        $display("FAIL reset_outs[%0d] got %b exp 00000", i, {gnt_0, gnt_1, ram_we, rvalid_0, rvalid_1});
      end
    end
    hresetn = 1; we_0 = 0;
    #1;
    n_cmp++;
    if ({gnt_0, gnt_1} !== 2'b10) begin
      n_err++; $display("FAIL reset_release_gnt got %b exp 10", {gnt_0, gnt_1});
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (rvalid_0 !== 1'b1 || rd_0 !== 32'hDEAD0100) begin
      n_err++; $display("FAIL reset_first_read got v=%b d=%h exp v=1 d=dead0100", rvalid_0, rd_0);
    end
    tick();
  endtask

  task automatic test_uncontested_read();
    do_reset();
    req_1 = 1; we_1 = 0; addr_1 = 32'h40;
    #1;
    n_cmp++;
    if ({gnt_0, gnt_1} !== 2'b01 || ram_addr !== 32'h40 || ram_we !== 1'b0) begin
      n_err++; $display("FAIL ur_grant got g=%b a=%h we=%b exp g=01 a=40 we=0", {gnt_0, gnt_1}, ram_addr, ram_we);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (rvalid_1 !== 1'b1 || rvalid_0 !== 1'b0 || rd_1 !== 32'hDEAD0040) begin
      n_err++; $display("FAIL ur_rdata got v1=%b v0=%b d=%h exp v1=1 v0=0 d=dead0040", rvalid_1, rvalid_0, rd_1);
    end
    tick();
    #1;
    n_cmp++;
    if (rvalid_1 !== 1'b0) begin
      n_err++; $display("FAIL ur_rvalid_drop got %b exp 0", rvalid_1);
    end
  endtask

  task automatic test_contention();
    logic [31:0] exp_a;
    logic [31:0] exp_d;
    do_reset();
    req_0 = 1; req_1 = 1; addr_0 = 32'h10; addr_1 = 32'h20;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) idle();
      #1;
      if (k < 4) begin
        exp_a = (k % 2 == 0) ? 32'h10 : 32'h20;
        n_cmp++;
        if (gnt_0 !== (k % 2 == 0) || gnt_1 !== (k % 2 == 1) || ram_addr !== exp_a) begin
          n_err++; $display("FAIL cont_grant[%0d] got g=%b a=%h exp a=%h", k, {gnt_0, gnt_1}, ram_addr, exp_a);
        end
      end
      if (k > 0) begin
        exp_d = (k % 2 == 1) ? 32'hDEAD0010 : 32'hDEAD0020;
        n_cmp++;
        if (rvalid_0 !== (k % 2 == 1) || rvalid_1 !== (k % 2 == 0) || ram_rd !== exp_d) begin
          n_err++; $display("FAIL cont_rvalid[%0d] got v=%b%b d=%h exp d=%h", k, rvalid_0, rvalid_1, ram_rd, exp_d);
        end
      end
      tick();
    end
  endtask

  task automatic test_locked_burst();
    do_reset();
    req_0 = 1; addr_0 = 32'h10; addr_1 = 32'h20;
    tick();
    req_1 = 1; lock_1 = 1;
    for (int c = 0; c < 10; c++) begin
      #1;
      n_cmp++;
      if (gnt_1 !== (c != 8) || gnt_0 !== (c == 8)) begin
        n_err++; $display("FAIL burst_cyc[%0d] got g0=%b g1=%b exp g1=%b", c, gnt_0, gnt_1, c != 8);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_early_unlock();
    do_reset();
    req_0 = 1; lock_0 = 1; req_1 = 1;
    for (int c = 0; c < 5; c++) begin
      if (c == 3) lock_0 = 0;
      #1;
      n_cmp++;
      if (gnt_0 !== (c != 3) || gnt_1 !== (c == 3)) begin
        n_err++; $display("FAIL unlock_cyc[%0d] got g0=%b g1=%b exp g1=%b", c, gnt_0, gnt_1, c == 3);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_write();
    do_reset();
    req_0 = 1; we_0 = 1; addr_0 = 32'h10; wd_0 = 32'h12345678;
    #1;
    n_cmp++;
    if (gnt_0 !== 1'b1 || ram_we !== 1'b1 || ram_wd !== 32'h12345678 || ram_addr !== 32'h10) begin
      n_err++; $display("FAIL wr_cmd got g=%b we=%b wd=%h a=%h exp 1 1 12345678 10", gnt_0, ram_we, ram_wd, ram_addr);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (ram_we !== 1'b0 || rvalid_0 !== 1'b0 || rvalid_1 !== 1'b0) begin
      n_err++; $display("FAIL wr_after got we=%b v=%b%b exp 0 00", ram_we, rvalid_0, rvalid_1);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    req_0 = 1; addr_0 = 32'h30;
    tick();
    we_0 = 1; addr_0 = 32'h34; wd_0 = 32'hCAFE0001;
    #1;
    n_cmp++;
    if (ram_we !== 1'b1 || ram_addr !== 32'h34 || rvalid_0 !== 1'b1 || rd_0 !== 32'hDEAD0030) begin
      n_err++; $display("FAIL b2b_rw got we=%b a=%h v=%b d=%h exp 1 34 1 dead0030", ram_we, ram_addr, rvalid_0, rd_0);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (rvalid_0 !== 1'b0 || ram_we !== 1'b0) begin
      n_err++; $display("FAIL b2b_wr_norv got v=%b we=%b exp 0 0", rvalid_0, ram_we);
    end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req_1 = 1; lock_1 = 1; addr_1 = 32'h50;
    tick();
    tick();
    hresetn = 0;
    #1;
    n_cmp++;
    if ({gnt_0, gnt_1} !== 2'b00) begin
      n_err++; $display("FAIL rst_burst_gnt got %b exp 00", {gnt_0, gnt_1});
    end
    tick();
    #1;
    n_cmp++;
    if (rvalid_1 !== 1'b0 || rvalid_0 !== 1'b0) begin
      n_err++; $display("FAIL rst_burst_rvalid got %b%b exp 00", rvalid_0, rvalid_1);
    end
    hresetn = 1; req_0 = 1;
    #1;
    n_cmp++;
    if ({gnt_0, gnt_1} !== 2'b10) begin
      n_err++; $display("FAIL rst_burst_arb got %b exp 10", {gnt_0, gnt_1});
    end
    tick();
    idle();
  endtask

  initial begin
    idle();
    hresetn = 0;
    test_reset();
    test_uncontested_read();
    test_contention();
    test_locked_burst();
    test_early_unlock();
    test_write();
    test_back_to_back();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
